// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and defaults for the serial sequence detector controller.
package seq_det_ctrl_pkg;

    localparam int unsigned PAT_W_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFGD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // A pattern length is usable when it is non-zero and fits the window.
    function automatic logic len_is_legal(input logic [3:0] len, input int unsigned pat_w);
        return (len != 4'd0) && (32'(len) <= pat_w);
    endfunction

endpackage

// File: rtl/serial_pattern_match.sv
// Shift window, fill counter and masked compare for serial pattern detection.
module serial_pattern_match #(
    parameter int unsigned PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             signal,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       len,
    input  logic             overlap,
    output logic             hit
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  mask;
    logic [PAT_W-1:0]  cand;
    logic              filled;

    // Candidate window including the bit arriving this edge, and the length mask.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        cand   = (window_q << 1) | PAT_W'(signal);
        filled = (32'(fill_q) + 32'd1) >= 32'(len);
        hit    = shift_en && filled && (((cand ^ pattern) & mask) == '0);
    end

    // Window/fill update; a non-overlapping hit restarts the fill count only.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        if (clear) begin
            window_d = '0;
            fill_d   = '0;
        end else if (shift_en) begin
            window_d = cand;
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (32'(fill_q) < PAT_W) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Window and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence detector controller: config handshake, run FSM and match counting.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             signal,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q;
    logic [3:0]       len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic             err_q;
    logic             match_q;
    logic [CNT_W-1:0] count_q;

    logic             cfg_fire;
    logic             cfg_legal;
    logic             start_fire;
    logic             running;
    logic             hit;
    logic [CNT_W-1:0] count_inc;
    logic             target_reached;

    // Handshake decode; a config offered in CFGD wins over start.
    always_comb begin
        cfg_fire       = cfg_valid && cfg_ready;
        cfg_legal      = len_is_legal(cfg_len, PAT_W);
        start_fire     = (state_q == CFGD) && start && !cfg_fire;
        running        = (state_q == RUN);
        count_inc      = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        target_reached = hit && (target_q != '0) && (count_inc == target_q);
    end

    serial_pattern_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_fire),
        .shift_en (running),
        .signal   (signal),
        .pattern  (pattern_q),
        .len      (len_q),
        .overlap  (overlap_q),
        .hit      (hit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_fire) begin
                    state_d = cfg_legal ? CFGD : IDLE;
                end
            end
            CFGD: begin
                if (cfg_fire) begin
                    state_d = cfg_legal ? CFGD : IDLE;
                end else if (start_fire) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (target_reached || abort) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = CFGD;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        cfg_ready = (state_q == IDLE) || (state_q == CFGD);
        busy      = (state_q == RUN);
        done      = (state_q == FIN);
    end

    // Configuration latch and sticky error; illegal lengths leave settings untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            err_q     <= 1'b0;
        end else if (cfg_fire) begin
            if (cfg_legal) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
                err_q     <= 1'b0;
            end else begin
                err_q     <= 1'b1;
            end
        end
    end

    // Match pulse and saturating run counter; count holds after the run ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            match_q <= running && hit;
            if (start_fire) begin
                count_q <= '0;
            end else if (running && hit) begin
                count_q <= count_inc;
            end
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a bit-history model predicts per-cycle outputs.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       signal;
    logic       match;
    logic [7:0] match_count;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .signal      (signal),
        .match       (match),
        .match_count (match_count),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct packed {
        logic       m;
        logic [7:0] cnt;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ov;
    int         m_tgt;
    int         m_cnt;
    bit         m_run;
    bit         hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop one prediction per cycle, between active edges.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq("sb_match", match, e.m);
            check_eq("sb_count", match_count, e.cnt);
            check_eq("sb_busy", busy, e.bsy);
            check_eq("sb_done", done, e.dn);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input int len, input logic ov, input int tgt);
        logic legal;
        legal       = (len >= 1) && (len <= 8);
        cfg_valid   = 1'b1;
        cfg_pattern = pat;
        cfg_len     = 4'(len);
        cfg_overlap = ov;
        cfg_target  = 8'(tgt);
        tick();
        cfg_valid   = 1'b0;
        if (legal) begin
            m_pat = pat;
            m_len = len;
            m_ov  = ov;
            m_tgt = tgt;
        end
        check_eq("cfg_err", err, !legal);
        check_eq("cfg_ready_after_cfg", cfg_ready, 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        hist.delete();
        m_cnt = 0;
        m_run = 1'b1;
        check_eq("start_busy", busy, 1);
        check_eq("start_count", match_count, 0);
        check_eq("start_ready", cfg_ready, 0);
    endtask

    // Drive one serial bit (optionally with abort) and predict the outputs after the edge.
    task automatic drive_bit(input logic b, input logic ab);
        exp_t e;
        bit   hit;
        bit   fin;
        signal = b;
        abort  = ab;
        if (m_run) begin
            hist.push_back(b);
            hit = 1'b0;
            if (hist.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (hist[hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                end
            end
            if (hit) begin
                if (m_cnt != 255) m_cnt++;
                if (!m_ov) hist.delete();
            end
            fin = ab || (hit && (m_tgt != 0) && (m_cnt == m_tgt));
            e = '{m: hit, cnt: 8'(m_cnt), bsy: !fin, dn: fin};
            if (fin) m_run = 1'b0;
        end else begin
            e = '{m: 1'b0, cnt: 8'(m_cnt), bsy: 1'b0, dn: 1'b0};
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        abort = 1'b0;
    endtask

    task automatic drive_stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(bits[i], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; start = 0; abort = 0; signal = 0;
        m_pat = 0; m_len = 0; m_ov = 0; m_tgt = 0; m_cnt = 0; m_run = 0;
        tick(); tick();
        check_eq("rst_ready", cfg_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_match", match, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_count", match_count, 0);
        rst = 1'b0;
        tick();

        // Non-overlap 11011 over 1101111011: matches after bits 5 and 10
        do_cfg(8'b0001_1011, 5, 1'b0, 0);
        do_start();
        drive_stream(16'b11_0111_1011, 10);
        drive_bit(1'b0, 1'b1);
        check_eq("nonov_total", match_count, 2);
        tick();
        check_eq("fin_to_cfgd_ready", cfg_ready, 1);
        check_eq("fin_to_cfgd_done", done, 0);

        // Overlap on 11011011: two matches
        do_cfg(8'b0001_1011, 5, 1'b1, 0);
        do_start();
        drive_stream(16'b1101_1011, 8);
        check_eq("ov_total", match_count, 2);
        drive_bit(1'b0, 1'b1);
        tick();

        // Non-overlap on the same stream: one match
        do_cfg(8'b0001_1011, 5, 1'b0, 0);
        do_start();
        drive_stream(16'b1101_1011, 8);
        check_eq("nonov_same_total", match_count, 1);
        drive_bit(1'b0, 1'b1);
        tick();

        // Target 2, pattern 11: stops after bit 3, bit 4 ignored
        do_cfg(8'b0000_0011, 2, 1'b1, 2);
        do_start();
        drive_stream(16'b1111, 4);
        check_eq("tgt_total", match_count, 2);
        check_eq("tgt_ready", cfg_ready, 1);

        // Config and start together in CFGD: config wins
        cfg_valid = 1'b1; cfg_pattern = 8'b0000_0101; cfg_len = 4'd3;
        cfg_overlap = 1'b0; cfg_target = 8'd0; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        m_pat = 8'b0000_0101; m_len = 3; m_ov = 1'b0; m_tgt = 0;
        check_eq("prio_busy", busy, 0);
        check_eq("prio_ready", cfg_ready, 1);

        // Config offered during RUN is refused and leaves settings intact
        do_start();
        cfg_valid = 1'b1; cfg_pattern = 8'b0000_0000; cfg_len = 4'd2;
        drive_bit(1'b1, 1'b0);
        check_eq("run_cfg_ready", cfg_ready, 0);
        drive_bit(1'b0, 1'b0);
        cfg_valid = 1'b0;
        drive_bit(1'b1, 1'b0);
        check_eq("run_cfg_kept", match_count, 1);
        drive_bit(1'b0, 1'b1);
        tick();

        // Abort on the same edge as a detection still counts and pulses
        do_cfg(8'b0000_0011, 2, 1'b0, 0);
        do_start();
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        tick();
        check_eq("abort_hit_total", match_count, 1);

        // Reset mid-RUN after 3 bits
        do_cfg(8'b0000_0011, 2, 1'b1, 0);
        do_start();
        drive_stream(16'b111, 3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_run = 1'b0;
        m_cnt = 0;
        check_eq("mid_rst_match", match, 0);
        check_eq("mid_rst_count", match_count, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_ready", cfg_ready, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_no_done", done, 0);
        end

        // Illegal lengths in IDLE: err set, stays IDLE, start ignored
        do_cfg(8'b0000_0001, 0, 1'b0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("idle_start_ignored", busy, 0);
        check_eq("err_sticky", err, 1);
        do_cfg(8'b0000_0001, 9, 1'b0, 0);
        do_cfg(8'b0000_0001, 1, 1'b0, 0);
        do_start();
        drive_stream(16'b0101, 4);
        drive_bit(1'b0, 1'b1);
        tick();
        check_eq("len1_total", match_count, 2);

        @(negedge clk);
        #1;
        check_eq("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 8, SHALL set the maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the match counter and target.
REQ-003 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  in  1  configuration offered.
REQ-006 cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
REQ-007 cfg_pattern  in  PAT_W  pattern; bit 0 is the last bit received.
REQ-008 cfg_len  in  4  pattern length; legal range 1..PAT_W.
REQ-009 cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-010 cfg_target  in  CNT_W  number of matches that ends a run; 0 = run until abort.
REQ-011 start  in  1  arm the detector; only honoured in state CFGD.
REQ-012 abort  in  1  end the current run immediately.
REQ-013 signal  in  1  serial input; sampled only in state RUN.
REQ-014 match  out  1  one-cycle pulse per detection.
REQ-015 match_count  out  CNT_W  detections in the current run.
REQ-016 busy  out  1  high in state RUN.
REQ-017 done  out  1  one-cycle pulse when a run ends.
REQ-018 err  out  1  sticky flag for an illegal cfg_len; cleared by the next legal config or by reset.

Function
REQ-019 States SHALL be IDLE, CFGD, RUN and FIN; the reset state SHALL be IDLE.
REQ-020 cfg_ready SHALL equal (state==IDLE || state==CFGD), so configuration is refused during RUN and FIN.
REQ-021 An accepted configuration with a legal cfg_len SHALL latch pattern, len, overlap and target, clear err, and move to CFGD.
REQ-022 An accepted configuration with cfg_len==0 or cfg_len>PAT_W SHALL set err, latch nothing and move to IDLE.
REQ-023 start in CFGD SHALL clear the shift window, the fill counter and match_count, and move to RUN on the next edge.
REQ-024 In RUN, each edge SHALL shift signal into window bit 0 and increment the fill counter, saturating at PAT_W.
REQ-025 A detection SHALL occur at an edge when fill+1>=len and the low len bits of {window,signal} equal the low len bits of the pattern.
REQ-026 On a detection:
  - match SHALL be registered and high for exactly the cycle after the sampling edge.
  - match_count SHALL increment, saturating at all-ones.
  - In non-overlap mode the fill counter SHALL reset to 0, so the next match needs len fresh bits.
  - In overlap mode the window and fill counter SHALL be kept.
REQ-027 When cfg_target!=0 and match_count reaches cfg_target, the state SHALL move to FIN in the same edge and no further bits SHALL be sampled.
REQ-028 abort in RUN SHALL move to FIN; a detection completing on the same edge SHALL still count and pulse.
REQ-029 FIN SHALL last one cycle, pulse done, and then return to CFGD with the configuration retained; match_count SHALL hold until the next start.
REQ-030 start and abort outside the states named in REQ-011 and REQ-028 SHALL be ignored.
REQ-031 When cfg_valid and start are high together in CFGD, the configuration SHALL take priority and start SHALL be ignored.

Reset
REQ-032 While rst is high: state=IDLE; match, done, busy, err=0; match_count=0; window, fill and latched configuration=0; cfg_ready=1.
REQ-033 Reset asserted mid-RUN SHALL abort without a done pulse.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, CFGD, RUN, FIN) and the defaults for PAT_W and CNT_W.
REQ-035 Window, fill counter and compare logic SHALL be one sub-module, serial_pattern_match; seq_det_ctrl SHALL own the FSM, configuration registers, counter and handshake.

Verification
REQ-036 Config 11011, len 5, non-overlap, target 0; start; stream 1101111011 -> match pulses after bits 5 and 10; match_count=2.
REQ-037 Same config in overlap mode; stream 11011011 -> 2 matches (bits 5 and 8). Non-overlap mode on the same stream -> 1 match.
REQ-038 Target=2, overlap; stream 1111 with pattern 11, len 2 -> matches at bits 2 and 3; done one cycle after FIN entry; bit 4 ignored; match_count=2.
REQ-039 cfg_valid during RUN -> cfg_ready=0 and no configuration change. cfg_len=0 in IDLE -> err=1, state stays IDLE, start ignored.
REQ-040 rst pulse mid-RUN after 3 bits -> all outputs 0 immediately, no done pulse, cfg_ready=1.
